rom_streamer: RTL

Read initiator for the synchronous-read ROM. On a start command it fetches `word_count` consecutive words beginning at `start_addr` and delivers them in order on a valid/ready output stream. It absorbs the memory's one-cycle read latency and downstream backpressure without losing or duplicating words. It sits between instruction/data ROM instances and any consumer that needs burst reads, such as boot copy or sprite/table loaders.

---
 rtl/mem_pkg.sv | 12 +
 rtl/fifo2.sv | 56 +++++
 rtl/rom_streamer.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side definitions: streamer state encoding and buffer depth.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/fifo2.sv
// Two-entry synchronous FIFO with a registered head word and occupancy count.
// The head register keeps its last value after the final pop.
module fifo2
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] tail;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != FULL) || do_pop);

    // Head/tail storage and occupancy update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == FULL) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == FULL) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_streamer.sv
// Burst read initiator for a synchronous-read ROM with a valid/ready output.
// Reads are issued only while buffered words plus the in-flight word leave
// room in the two-entry FIFO, so backpressure never overflows it.
module rom_streamer
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int COUNT_WIDTH   = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [COUNT_WIDTH-1:0]   word_count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    stream_state_t           state_q;
    stream_state_t           state_d;
    logic                    done_d;
    logic [COUNT_WIDTH-1:0]  issue_left;
    logic [COUNT_WIDTH-1:0]  deliver_left;
    logic                    inflight;
    logic                    issue;
    logic                    pop;
    logic                    accept;
    logic [1:0]              fifo_count;
    logic [1:0]              level_after_pop;

    assign out_valid       = (fifo_count != 2'd0);
    assign pop             = out_valid && out_ready;
    assign level_after_pop = fifo_count - {1'b0, pop};
    assign issue           = (state_q == ST_FETCH) &&
                             ((level_after_pop + {1'b0, inflight}) < 2'(FIFO_DEPTH));
    assign accept          = (state_q == ST_IDLE) && start && (word_count != '0);
    assign busy            = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and completion decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (word_count != '0)) state_d = ST_FETCH;
                else if (start)                  done_d  = 1'b1;
            end
            ST_FETCH: begin
                if (issue && (issue_left == COUNT_WIDTH'(1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && (deliver_left == COUNT_WIDTH'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address, remaining counters, in-flight flag and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr     <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
            inflight     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= done_d;
            inflight <= issue;
            if (accept) begin
                mem_addr     <= start_addr;
                issue_left   <= word_count;
                deliver_left <= word_count;
            end else begin
                if (issue) begin
                    mem_addr   <= mem_addr + ADDRESS_WIDTH'(1);
                    issue_left <= issue_left - COUNT_WIDTH'(1);
                end
                if (pop && (deliver_left != '0)) begin
                    deliver_left <= deliver_left - COUNT_WIDTH'(1);
                end
            end
        end
    end

    fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (mem_data),
        .pop   (pop),
        .head  (out_data),
        .count (fifo_count)
    );

endmodule
